dmem_burst_responder: RTL and testbench

- Memory-side responder for the data-cache line fill/flush protocol (mem_addr / mem_rdreq / mem_wrreq / mem_out / mem_valid / mem_burstlen).
- Owns an on-chip word-addressed RAM.
- Serves fixed-length read bursts with programmable latency and accepts back-to-back write bursts.
- Sits between the dcache controller and the memory map; it is the bench target and the FPGA scratch memory for the data side.

---
 rtl/dmem_burst_responder.sv | 120 ++++++++++++
 tb/tb_dmem_burst_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dmem_burst_responder.sv
// dmem_burst_responder: word-addressed scratch RAM serving fixed-length read bursts
// with programmable latency and accepting back-to-back write bursts for the dcache.
module dmem_burst_responder #(
    parameter int ADDRBITS    = 32,
    parameter int DATABITS    = 32,
    parameter int MEMADDRBITS = 10,
    parameter int BURSTLEN    = 8,
    parameter int RDLATENCY   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDRBITS-1:0] mem_addr,
    input  logic                mem_rdreq,
    input  logic                mem_wrreq,
    input  logic [DATABITS-1:0] mem_in,
    output logic [DATABITS-1:0] mem_out,
    output logic                mem_valid,
    output logic [15:0]         mem_burstlen,
    output logic                mem_busy,
    output logic                mem_err
);
    localparam logic [1:0] IDLE = 2'd0, RDWAIT = 2'd1, RDBURST = 2'd2, WRBURST = 2'd3;
    localparam logic [15:0] BL = 16'(BURSTLEN);
    localparam logic [MEMADDRBITS-1:0] ONE = 1;
    logic [DATABITS-1:0] ram [2**MEMADDRBITS];
    logic [DATABITS-1:0] rdata_q;
    logic [1:0] state_q, state_d;
    logic [MEMADDRBITS-1:0] ptr_q, ptr_d, idx, addr;
    logic [15:0] cnt_q, cnt_d;
    logic valid_q, valid_d, err_q, err_d, we;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr[ADDRBITS-1:MEMADDRBITS+2], mem_addr[1:0]};
    assign idx = mem_addr[MEMADDRBITS+1:2];
    // Single shared port: in IDLE the incoming address is used directly so the
    // first read word is fetched on the request edge when RDLATENCY is 1.
    assign addr = state_q == IDLE ? idx : ptr_q;
    assign we = !reset && (state_q == WRBURST || (state_q == IDLE && mem_wrreq));
    assign mem_out = valid_q ? rdata_q : '0;
    assign mem_valid = valid_q;
    assign mem_busy = state_q != IDLE;
    assign mem_err = err_q;
    assign mem_burstlen = BL;

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        valid_d = 1'b0;
        err_d = err_q | (state_q != IDLE && (mem_rdreq || mem_wrreq)) |
                (state_q == IDLE && mem_rdreq && mem_wrreq);
        case (state_q)
            IDLE: begin
                if (mem_wrreq) begin
                    state_d = BURSTLEN > 1 ? WRBURST : IDLE;
                    ptr_d = idx + ONE;
                    cnt_d = 16'd1;
                end else if (mem_rdreq && RDLATENCY == 1) begin
                    state_d = RDBURST;
                    valid_d = 1'b1;
                    ptr_d = idx + ONE;
                    cnt_d = 16'd1;
                end else if (mem_rdreq) begin
                    state_d = RDWAIT;
                    ptr_d = idx;
                    cnt_d = 16'(RDLATENCY - 1);
                end
            end
            RDWAIT: begin
                if (cnt_q == 16'd1) begin
                    state_d = RDBURST;
                    valid_d = 1'b1;
                    ptr_d = ptr_q + ONE;
                    cnt_d = 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RDBURST: begin
                if (cnt_q == BL) begin
                    state_d = IDLE;
                    cnt_d = 16'd0;
                end else begin
                    valid_d = 1'b1;
                    ptr_d = ptr_q + ONE;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                ptr_d = ptr_q + ONE;
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == BL - 16'd1) begin
                    state_d = IDLE;
                    cnt_d = 16'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) ram[addr] <= mem_in;
        rdata_q <= ram[addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            cnt_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            valid_q <= valid_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_dmem_burst_responder.sv
// tb_dmem_burst_responder: scoreboard bench; expected read words are queued from a
// shadow memory when a read is issued and popped whenever mem_valid is seen.
module tb_dmem_burst_responder;
    localparam int BL = 8, LAT = 2;
    logic clk = 1'b0, reset = 1'b1, mem_rdreq = 1'b0, mem_wrreq = 1'b0;
    logic [31:0] mem_addr = '0, mem_in = '0, mem_out;
    logic mem_valid, mem_busy, mem_err;
    logic [15:0] mem_burstlen;
    logic [31:0] model [1024];
    logic [31:0] exp_q [$];
    int n_chk = 0, n_err = 0;

    dmem_burst_responder dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdreq(mem_rdreq),
        .mem_wrreq(mem_wrreq), .mem_in(mem_in), .mem_out(mem_out), .mem_valid(mem_valid),
        .mem_burstlen(mem_burstlen), .mem_busy(mem_busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else check("rd_data", mem_out, exp_q.pop_front());
        end else begin
            check("out_idle_zero", mem_out, 32'd0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;
        tick;
        tick;
        check("rst_burstlen", {16'd0, mem_burstlen}, 32'd8);
        reset = 1'b0;
        check("rst_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_busy", {31'd0, mem_busy}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [31:0] base, input bit both,
                            input int rst_beat);
        int unsigned idx;
        idx = (addr >> 2) & 32'h3FF;
        for (int i = 0; i < BL; i++) begin
            mem_addr = i == 0 ? addr : 32'hDEAD_BEEF;
            mem_wrreq = i == 0;
            mem_rdreq = both && i == 0;
            mem_in = base + i;
            reset = i == rst_beat;
            tick;
            if (i == rst_beat) begin
                reset = 1'b0;
                mem_wrreq = 1'b0;
                check("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
                check("rst_mid_busy", {31'd0, mem_busy}, 32'd0);
                return;
            end
            model[(idx + i) % 1024] = base + i;
            if (i == 0) check("wr_busy", {31'd0, mem_busy}, 32'd1);
            mem_wrreq = 1'b0;
            mem_rdreq = 1'b0;
        end
        mem_in = '0;
        check("wr_done_busy", {31'd0, mem_busy}, 32'd0);
    endtask

    task automatic rd_burst(input logic [31:0] addr, input int poke);
        int unsigned idx;
        idx = (addr >> 2) & 32'h3FF;
        for (int k = 0; k < BL; k++) exp_q.push_back(model[(idx + k) % 1024]);
        mem_addr = addr;
        mem_rdreq = 1'b1;
        tick;
        mem_rdreq = 1'b0;
        mem_addr = 32'h5555_5555;
        for (int i = 1; i < LAT; i++) begin
            check("lat_valid", {31'd0, mem_valid}, 32'd0);
            check("lat_busy", {31'd0, mem_busy}, 32'd1);
            tick;
        end
        for (int k = 0; k < BL; k++) begin
            check("beat_valid", {31'd0, mem_valid}, 32'd1);
            check("beat_busy", {31'd0, mem_busy}, 32'd1);
            mem_rdreq = k == poke;
            tick;
        end
        mem_rdreq = 1'b0;
        check("end_valid", {31'd0, mem_valid}, 32'd0);
        check("end_busy", {31'd0, mem_busy}, 32'd0);
        check("rd_drain", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1;
        check("burstlen_during_reset", {16'd0, mem_burstlen}, 32'd8);
        do_reset;
        repeat (5) tick;
        check("idle_valid", {31'd0, mem_valid}, 32'd0);
        check("idle_busy", {31'd0, mem_busy}, 32'd0);
        check("idle_err", {31'd0, mem_err}, 32'd0);
        check("idle_out", mem_out, 32'd0);
        wr_burst(32'h40, 32'hA0, 1'b0, -1);
        rd_burst(32'h40, -1);
        rd_burst(32'hFFFF_F043, -1);
        wr_burst(32'h0, 32'hB0, 1'b0, -1);
        wr_burst(32'hFF8, 32'h1, 1'b0, -1);
        rd_burst(32'h0, -1);
        rd_burst(32'hFF8, -1);
        check("no_err_yet", {31'd0, mem_err}, 32'd0);
        rd_burst(32'h40, 3);
        check("err_set", {31'd0, mem_err}, 32'd1);
        repeat (3) tick;
        check("err_sticky", {31'd0, mem_err}, 32'd1);
        do_reset;
        wr_burst(32'h100, 32'hC0, 1'b1, -1);
        check("both_err", {31'd0, mem_err}, 32'd1);
        rd_burst(32'h100, -1);
        do_reset;
        wr_burst(32'h200, 32'hE0, 1'b0, -1);
        wr_burst(32'h200, 32'h10, 1'b0, 4);
        rd_burst(32'h200, -1);
        check("final_err", {31'd0, mem_err}, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
